adio_rx_deser: RTL and testbench
================================

Name: adio_rx_deser

Overview:
- Serial-to-parallel audio receiver, the capture-side counterpart of the DAC serializer.
- Takes codec-domain AUD_BCK, AUD_LRCK and AUD_DATA (ADC data, or DAC loopback for self-test).
- Left-justified, MSB-first, two channels. Oversamples all three lines in the iCLK_18_4 domain and delivers stereo sample pairs through a valid/ready handshake to downstream DSP or loopback checkers.

Parameters:
- DATA_WIDTH, 16, bits per channel word; the output sample width.
- SYNC_STAGES, 2, synchronizer flops on each serial input (minimum 2).

Ports:
- iCLK_18_4  in  1  system clock, 18.432 MHz.
- iRST_N  in  1  reset.
- iAUD_BCK  in  1  bit clock from codec; asynchronous to iCLK_18_4.
- iAUD_LRCK  in  1  frame clock; 1 = left, 0 = right.
- iAUD_DATA  in  1  serial data; valid at BCK rising edge.
- iReady  in  1  downstream accepts pair.
- iErrClr  in  1  clears sticky flags.
- oLeft  out  DATA_WIDTH  left sample, two's complement.
- oRight  out  DATA_WIDTH  right sample.
- oValid  out  1  pair available.
- oOverrun  out  1  sticky: pair dropped due to backpressure.
- oFrameErr  out  1  sticky: short word detected.

Behaviour:
- Reset: iRST_N is asynchronous, active-low; clock is iCLK_18_4.
  - All outputs reset to 0; state S_ALIGN.
  - Synchronizers, shift register and bit counter reset to 0.
  - Reset mid-frame discards any partial data.
- Input conditioning:
  - BCK, LRCK and DATA each pass through SYNC_STAGES flops with equal delay.
  - One extra BCK flop provides edge detect. A bit event is one iCLK cycle where the synced BCK is 1 and its delayed copy is 0.
  - BCK high and low phases must each be at least 3 iCLK cycles; nominal is 6/6.
- At each bit event, sample LRCK_s and DATA_s. lr_change = LRCK_s != lr_prev; lr_prev updates on every bit event.
- Bit capture:
  - lr_change event: this bit is the MSB of a new word. shift <= {0..., DATA_s}; bitcnt <= 1.
  - Otherwise, if bitcnt < DATA_WIDTH: shift <= {shift[DW-2:0], DATA_s}; bitcnt++.
  - Otherwise the extra bit is ignored and bitcnt saturates. This is not an error, so 24/32-BCK half-frames are supported.
- FSM. All decisions are made only on bit events with lr_change = 1 (the commit cycle). The shift/bitcnt values used are those before the reload.
  - S_ALIGN: wait for an LRCK 0->1 change -> S_LEFT. A 1->0 change is ignored.
  - S_LEFT, on LRCK 1->0:
    - bitcnt == DW: left_hold <= shift; -> S_RIGHT.
    - Else: set oFrameErr; -> S_ALIGN.
  - S_RIGHT, on LRCK 0->1:
    - bitcnt == DW: pair commit with (left_hold, shift); -> S_LEFT.
    - Else: set oFrameErr; -> S_LEFT, because this edge already starts a valid left word.
- Pair commit / output handshake:
  - Transfer occurs when oValid && iReady.
  - On commit, if !oValid or a transfer happens that cycle: load oLeft/oRight and set oValid = 1 on the next iCLK edge. Latency is 1 iCLK cycle after the commit cycle.
  - On commit while oValid && !iReady: drop the new pair, set oOverrun, keep outputs unchanged.
  - Transfer without commit: oValid <= 0.
  - oLeft/oRight stay stable while oValid is high; they keep their last values after transfer.
- Sticky flags:
  - iErrClr clears oOverrun and oFrameErr.
  - If a set event and iErrClr occur in the same cycle, set wins.
- Within one frame, no sample is delivered before the first complete left word after alignment.

Test Plan:
- Reset, then a BFM drives a 12-clk BCK period, 384-clk LRCK period, with L=16'h0BAE, R=16'h8000, iReady=1 -> first oValid after the first full L+R following an LRCK rise; oLeft=16'h0BAE, oRight=16'h8000; oValid is high exactly 1 cycle per frame; flags remain 0.
- iReady=0 across 3 frames with pairs (1,2), (3,4), (5,6) -> oValid held with oLeft=1, oRight=2; oOverrun=1 after the second commit; then iReady=1 -> one transfer of (1,2), next frame delivers its own pair.
- Left half-frame truncated to 10 BCKs -> oFrameErr=1, no oValid that frame, FSM in S_ALIGN; next frame L=16'h7FFF, R=16'h0001 is delivered correctly.
- 24 BCK per half-frame, 16 data bits plus 8 zeros, L=16'hA5A5, R=16'h5A5A -> captured exactly, no flags.
- iRST_N pulsed low mid-right-word -> all outputs 0 immediately; after release, the first oValid only follows a complete new left plus right word.
- Overrun event coincident with iErrClr=1 -> oOverrun=1 afterwards; iErrClr alone on the next cycle -> 0.

Source files
------------

// File: rtl/adio_rx_deser.sv
// Left-justified, MSB-first stereo audio receiver: oversamples BCK/LRCK/DATA in the
// iCLK_18_4 domain, assembles left/right words and hands pairs out over valid/ready.
module adio_rx_deser #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         iCLK_18_4,
  input  logic                         iRST_N,
  input  logic                         iAUD_BCK,
  input  logic                         iAUD_LRCK,
  input  logic                         iAUD_DATA,
  input  logic                         iReady,
  input  logic                         iErrClr,
  output logic signed [DATA_WIDTH-1:0] oLeft,
  output logic signed [DATA_WIDTH-1:0] oRight,
  output logic                         oValid,
  output logic                         oOverrun,
  output logic                         oFrameErr
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {S_ALIGN, S_LEFT, S_RIGHT} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  bck_sync;
  logic [SYNC_STAGES-1:0]  lrck_sync;
  logic [SYNC_STAGES-1:0]  data_sync;
  logic                    bck_d;
  logic                    lr_prev;
  logic [DATA_WIDTH-1:0]   shift;
  logic [CNT_W-1:0]        bitcnt;
  logic signed [DATA_WIDTH-1:0] left_hold;

  logic bck_p0;
  logic lrck_p0;
  logic data_p0;
  logic vld_p0;
  logic lr_chg_p0;
  logic word_full_p0;

  // Stage p0: synchronized lines, BCK rising-edge detect and word-boundary detect
  assign bck_p0       = bck_sync[SYNC_STAGES-1];
  assign lrck_p0      = lrck_sync[SYNC_STAGES-1];
  assign data_p0      = data_sync[SYNC_STAGES-1];
  assign vld_p0       = bck_p0 & ~bck_d;
  assign lr_chg_p0    = vld_p0 & (lrck_p0 != lr_prev);
  assign word_full_p0 = (bitcnt == FULL_CNT);

  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      bck_sync  <= '0;
      lrck_sync <= '0;
      data_sync <= '0;
      bck_d     <= 1'b0;
      lr_prev   <= 1'b0;
      shift     <= '0;
      bitcnt    <= '0;
    end else begin
      bck_sync  <= {bck_sync[SYNC_STAGES-2:0], iAUD_BCK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], iAUD_LRCK};
      data_sync <= {data_sync[SYNC_STAGES-2:0], iAUD_DATA};
      bck_d     <= bck_p0;
      if (vld_p0) begin
        lr_prev <= lrck_p0;
        if (lr_chg_p0) begin
          shift  <= {{(DATA_WIDTH-1){1'b0}}, data_p0};
          bitcnt <= CNT_W'(1);
        end else if (bitcnt < FULL_CNT) begin
          shift  <= {shift[DATA_WIDTH-2:0], data_p0};
          bitcnt <= bitcnt + 1'b1;
        end
      end
    end
  end

  // Stage p1: framing FSM, pair hand-off and sticky flags; later assignments let a
  // set event override a same-cycle clear and a commit override the transfer drop.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= S_ALIGN;
      left_hold <= '0;
      oLeft     <= '0;
      oRight    <= '0;
      oValid    <= 1'b0;
      oOverrun  <= 1'b0;
      oFrameErr <= 1'b0;
    end else begin
      if (oValid && iReady) oValid <= 1'b0;
      if (iErrClr) begin
        oOverrun  <= 1'b0;
        oFrameErr <= 1'b0;
      end
      if (lr_chg_p0) begin
        case (state)
          S_ALIGN: if (lrck_p0) state <= S_LEFT;
          S_LEFT: begin
            if (!lrck_p0) begin
              if (word_full_p0) begin
                left_hold <= shift;
                state     <= S_RIGHT;
              end else begin
                oFrameErr <= 1'b1;
                state     <= S_ALIGN;
              end
            end
          end
          S_RIGHT: begin
            if (lrck_p0) begin
              state <= S_LEFT;
              if (!word_full_p0) begin
                oFrameErr <= 1'b1;
              end else if (!oValid || iReady) begin
                oLeft  <= left_hold;
                oRight <= shift;
                oValid <= 1'b1;
              end else begin
                oOverrun <= 1'b1;
              end
            end
          end
          default: state <= S_ALIGN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adio_rx_deser.sv
// Bench for adio_rx_deser: a half-frame BFM drives the codec lines, a word-level model
// predicts delivered pairs and sticky flags, and a monitor checks every output cycle.
module tb_adio_rx_deser;

  localparam int DW = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bck, lrck, dat, rdy, clr;
  logic [DW-1:0] left, right;
  logic          vld, ovr, ferr;

  int errors = 0;
  int checks = 0;

  // word-level model state
  logic [31:0]   exp_q[$];
  bit            exp_ov = 0, exp_fe = 0;
  bit            m_lfull = 0, m_have = 0;
  logic [DW-1:0] m_lval = '0, m_pl = '0, m_pr = '0;
  int            rst_at_bit = -1;
  bit            clr_hook = 0;

  // monitor history
  bit            pv = 0, prdy = 0;
  logic [DW-1:0] pl = '0, pr = '0;

  adio_rx_deser #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .iCLK_18_4(clk),
    .iRST_N   (rst_n),
    .iAUD_BCK (bck),
    .iAUD_LRCK(lrck),
    .iAUD_DATA(dat),
    .iReady   (rdy),
    .iErrClr  (clr),
    .oLeft    (left),
    .oRight   (right),
    .oValid   (vld),
    .oOverrun (ovr),
    .oFrameErr(ferr)
  );

  always #27 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_overrun"}, ovr, exp_ov);
    chk({tag, "_frame_err"}, ferr, exp_fe);
  endtask

  task automatic model_reset();
    m_lfull = 0;
    m_have  = 0;
    exp_ov  = 0;
    exp_fe  = 0;
    exp_q.delete();
  endtask

  // A pair is delivered at the LRCK rise that follows a full left word and a full
  // right word; it is dropped if the previous pair is still waiting on backpressure.
  task automatic model_commit();
    if (m_have) begin
      if (exp_q.size() != 0 && !rdy) exp_ov = 1;
      else exp_q.push_back({m_pl, m_pr});
    end
    m_have = 0;
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_ov = 0;
    exp_fe = 0;
  endtask

  // One half-frame of nbits BCK periods (6 clk low, 6 clk high), MSB first, zero padded.
  task automatic send_half(input bit lr, input logic [DW-1:0] val, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at_bit) begin
        rst_at_bit = -1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_zero", {vld, ovr, ferr, left, right}, 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end
      lrck = lr;
      dat  = (i < DW) ? val[DW-1-i] : 1'b0;
      repeat (6) @(negedge clk);
      if (i == 0 && lr) model_commit();
      bck = 1'b1;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        if (clr_hook && i == 0 && lr) begin
          if (c == SS) clr = 1'b1;
          if (c == SS + 1) chk("overrun_set_beats_clear", ovr, 1);
          if (c == SS + 2) begin
            clr = 1'b0;
            chk("overrun_clear_alone", ovr, 0);
            exp_ov = 0;
          end
        end
      end
      bck = 1'b0;
    end
    if (lr) begin
      m_lfull = (nbits >= DW);
      m_lval  = val;
      if (nbits < DW) exp_fe = 1;
    end else begin
      m_have = m_lfull && (nbits >= DW);
      m_pl   = m_lval;
      m_pr   = val;
      if (m_lfull && nbits < DW) exp_fe = 1;
      m_lfull = 0;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int nbits);
    send_half(1'b1, l, nbits);
    send_half(1'b0, r, nbits);
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      chk("reset_outputs", {vld, ovr, ferr, left, right}, 64'd0);
      pv = 0;
    end else begin
      if (pv && !prdy) chk("held_pair_stable", {vld, left, right}, {1'b1, pl, pr});
      if (vld && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pair: got %h/%h expected no pair", left, right);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if ({left, right} !== e) begin
            errors++;
            $display("FAIL pair: got %h/%h expected %h/%h", left, right, e[31:16], e[15:0]);
          end
        end
      end
      pv = vld; prdy = rdy; pl = left; pr = right;
    end
  end

  initial begin
    #(54 * 20000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bck = 1'b0; lrck = 1'b0; dat = 1'b0; rdy = 1'b1; clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {vld, ovr, ferr, left, right}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal frames, ready always high
    send_frame(16'h0BAE, 16'h8000, 16);
    send_frame(16'h0BAE, 16'h8000, 16);
    send_half(1'b1, 16'h0001, 16);
    chk("nominal_left", left, 16'h0BAE);
    chk("nominal_right", right, 16'h8000);
    chk("nominal_valid_dropped", vld, 0);
    check_flags("nominal");

    // Backpressure across three pairs
    rdy = 1'b0;
    send_half(1'b0, 16'h0002, 16);
    send_half(1'b1, 16'h0003, 16);
    chk("bp_first_commit_no_overrun", ovr, 0);
    send_half(1'b0, 16'h0004, 16);
    send_frame(16'h0005, 16'h0006, 16);
    chk("bp_held_valid", vld, 1);
    chk("bp_held_left", left, 16'h0001);
    chk("bp_held_right", right, 16'h0002);
    chk("bp_overrun_set", ovr, 1);
    send_half(1'b1, 16'h0007, 16);
    @(negedge clk);
    rdy = 1'b1;
    send_half(1'b0, 16'h0008, 16);
    check_flags("bp");
    clear_flags();

    // Truncated left word, then recovery
    send_half(1'b1, 16'hFFFF, 10);
    send_half(1'b0, 16'h1234, 16);
    check_flags("trunc");
    chk("trunc_frame_err", ferr, 1);
    send_frame(16'h7FFF, 16'h0001, 16);
    clear_flags();

    // 24 BCK per half-frame
    send_frame(16'hA5A5, 16'h5A5A, 24);
    chk("recover_left", left, 16'h7FFF);
    chk("recover_right", right, 16'h0001);
    send_half(1'b1, 16'h1111, 16);
    chk("wide_left", left, 16'hA5A5);
    chk("wide_right", right, 16'h5A5A);
    check_flags("wide");

    // Reset in the middle of a right word
    rst_at_bit = 5;
    send_half(1'b0, 16'h2222, 16);
    chk("post_reset_no_valid", vld, 0);
    send_frame(16'h3333, 16'h4444, 16);

    // Overrun coincident with clear
    rdy = 1'b0;
    send_half(1'b1, 16'h0009, 16);
    send_half(1'b0, 16'h000A, 16);
    chk("post_reset_pair_left", left, 16'h3333);
    chk("post_reset_pair_right", right, 16'h4444);
    clr_hook = 1;
    send_half(1'b1, 16'h000B, 16);
    clr_hook = 0;
    check_flags("coincident");
    rdy = 1'b1;
    send_half(1'b0, 16'h000C, 16);
    send_half(1'b1, 16'h0000, 16);
    repeat (50) @(negedge clk);
    chk("final_left", left, 16'h000B);
    chk("pending_pairs", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
